ixu_bundle_encoder: RTL and testbench
=====================================

Name: ixu_bundle_encoder

Overview:
Encoder side of the IXU instruction path. It accepts ALU micro-ops (op code, registers, immediate) over a valid/ready handshake. Each micro-op is encoded into a 32-bit RV32 R-type or I-type word, and the words are packed into SLOTS-wide VLIW bundles for the IXU issue stage. Partial bundles are padded with NOPs (32'h0), which the IXU decoder recognises.

Parameters:
SLOTS, 4, instruction slots per bundle (2..8)
TIMEOUT, 8, idle cycles before a partial bundle is force-closed (used only with the optional feature)

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
in_valid  in  1  micro-op valid
in_ready  out  1  encoder can accept a micro-op
in_op  in  4  ALU op: 0 ADD, 1 SUB, 2 XOR, 3 OR, 4 AND, 5 SLL, 6 SRL, 7 SRA, 8 SLT, 9 SLTU
in_is_imm  in  1  1 = I-type encoding, 0 = R-type
in_is_nop  in  1  fill this slot with 32'h0
in_rs1  in  5  source register 1
in_rs2  in  5  source register 2 (ignored when in_is_imm=1)
in_rd  in  5  destination register
in_imm  in  12  immediate (for shifts, only [4:0] is used)
flush  in  1  close the current partial bundle
bundle_valid  out  1  bundle available
bundle_ready  in  1  consumer takes the bundle
bundle_data  out  32*SLOTS  slot k occupies bits [32k+31:32k]
bundle_count  out  $clog2(SLOTS+1)  number of non-padding slots
err_illegal  out  1  one-cycle pulse: illegal micro-op accepted

Behaviour:
- Reset (sync, clk edge with rst=1):
  - bundle_valid=0, bundle_data=0, bundle_count=0, err_illegal=0
  - accumulator emptied; idle counter=0
  - in_ready=1 in the cycle after reset deasserts
  - reset mid-bundle discards both the accumulator and any pending output.
- Encoding (combinational, registered into the accumulator on accept):
  - opcode: 7'b0110011 (R-type) or 7'b0010011 (I-type)
  - funct3 per op: ADD/SUB 0, SLL 1, SLT 2, SLTU 3, XOR 4, SRL/SRA 5, OR 6, AND 7
  - R-type: funct7=7'h20 for SUB and SRA, else 7'h00
  - I-type: imm placed in [31:20]
  - I-type shifts (SLL/SRL/SRA): [31:25]=funct7 as for R-type, [24:20]=in_imm[4:0]
- Illegal micro-op: in_op>9, or SUB with in_is_imm=1.
  - The op is still accepted, but its slot is written with 32'h0.
  - It counts as a filled slot.
  - err_illegal pulses the cycle after accept.
- in_is_nop=1: slot written with 32'h0; counts as a filled slot; no error.
- Accept occurs when in_valid && in_ready. Slots fill from slot 0 upward.
- Slot counter cnt runs 0..SLOTS.
- Close condition, evaluated each cycle including a same-cycle accept:
  - the slot count after the accept equals SLOTS, or
  - flush=1 and the slot count after the accept is ≥1, or
  - timeout (optional feature).
- Output register:
  - Free when bundle_valid=0, or when bundle_valid && bundle_ready in the same cycle.
  - On close with the register free: the accumulator contents plus any same-cycle word move to the output register. Unused slots are 0.
  - On that transfer: bundle_count=filled slot count, cnt resets to 0, bundle_valid=1 from the next cycle.
  - Minimum latency: the accept that fills the last slot gives bundle_valid on the following cycle.
- Close with the register not free: the accumulator holds.
  - in_ready=0 while cnt==SLOTS.
  - A pending flush is latched and applied when the register frees.
- in_ready = (cnt < SLOTS).
- bundle_data and bundle_count are stable while bundle_valid && !bundle_ready.
- flush with an empty accumulator and no accept: no effect, no empty bundle.
- Back-to-back streaming with bundle_ready=1 sustains one micro-op per cycle.

Optional Feature:
IXU_ENC_TIMEOUT_EN:
- Defined: a $clog2(TIMEOUT+1)-bit idle counter increments each cycle with cnt≥1 and no accept. It resets on accept or close.
- Reaching TIMEOUT closes the partial bundle exactly as flush does.
- Undefined: no counter; partial bundles close only on full or flush. TIMEOUT is unused.

Test Plan:
- ADD x3,x1,x2 (op 0, rs1 1, rs2 2, rd 3), then flush -> one bundle: slot0=32'h002081B3, slots1..3=0, bundle_count=1.
- Four ops back-to-back, bundle_ready=1: SUB x5,x6,x7; ADDI x1,x0,-1 (imm 12'hFFF); SRAI x4,x4,3; NOP.
  - Expected slots: 32'h407302B3, 32'hFFF00093, 32'h40325213, 32'h0
  - bundle_count=4; bundle_valid on the cycle after the 4th accept.
- bundle_ready=0, feed 9 ops:
  - first bundle held stable
  - second bundle fills the accumulator, then in_ready drops with cnt=4
  - raise bundle_ready -> both bundles drain in order, then the 9th op is accepted.
- op=4'hC and SUB with is_imm=1, then flush -> err_illegal pulses twice; both slots 32'h0; bundle_count=2.
- flush coincident with the 2nd accept -> bundle_count=2 next cycle. flush with an empty accumulator -> bundle_valid stays 0.
- rst asserted with cnt=2 and bundle_valid=1 -> next cycle all outputs are 0 and the accumulator is empty. With IXU_ENC_TIMEOUT_EN defined, 1 op then 8 idle cycles -> bundle_count=1 bundle emitted.

Source files
------------

// File: rtl/ixu_bundle_encoder.sv
// Encodes ALU micro-ops into RV32 R/I-type words and packs them into SLOTS-wide NOP-padded bundles.
// Optional idle-timeout bundle close is enabled by defining IXU_ENC_TIMEOUT_EN.
module ixu_bundle_encoder #(
    parameter int SLOTS   = 4,
    parameter int TIMEOUT = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [3:0]                 in_op,
    input  logic                       in_is_imm,
    input  logic                       in_is_nop,
    input  logic [4:0]                 in_rs1,
    input  logic [4:0]                 in_rs2,
    input  logic [4:0]                 in_rd,
    input  logic [11:0]                in_imm,
    input  logic                       flush,
    output logic                       bundle_valid,
    input  logic                       bundle_ready,
    output logic [32*SLOTS-1:0]        bundle_data,
    output logic [$clog2(SLOTS+1)-1:0] bundle_count,
    output logic                       err_illegal
);
    localparam int CW = $clog2(SLOTS + 1);

    logic [SLOTS-1:0][31:0] acc, merged, bdata;
    logic [CW-1:0]          cnt, cnt_after;
    logic                   flush_pend;
    logic                   accept, out_free, close_req, do_close, timeout_hit;
    logic [2:0]             funct3;
    logic [6:0]             funct7;
    logic                   is_shift, illegal;
    logic [31:0]            word;

    always_comb begin
        funct3 = 3'd0;
        case (in_op)
            4'd0, 4'd1: funct3 = 3'd0;
            4'd5:       funct3 = 3'd1;
            4'd8:       funct3 = 3'd2;
            4'd9:       funct3 = 3'd3;
            4'd2:       funct3 = 3'd4;
            4'd6, 4'd7: funct3 = 3'd5;
            4'd3:       funct3 = 3'd6;
            4'd4:       funct3 = 3'd7;
            default:    funct3 = 3'd0;
        endcase
        funct7   = (in_op == 4'd1 || in_op == 4'd7) ? 7'h20 : 7'h00;
        is_shift = (in_op == 4'd5 || in_op == 4'd6 || in_op == 4'd7);
        illegal  = (in_op > 4'd9) || (in_op == 4'd1 && in_is_imm);
        if (in_is_nop || illegal)
            word = 32'h0;
        else if (!in_is_imm)
            word = {funct7, in_rs2, in_rs1, funct3, in_rd, 7'b0110011};
        else if (is_shift)
            word = {funct7, in_imm[4:0], in_rs1, funct3, in_rd, 7'b0010011};
        else
            word = {in_imm, in_rs1, funct3, in_rd, 7'b0010011};
    end

    assign in_ready  = (cnt < CW'(SLOTS));
    assign accept    = in_valid && in_ready;
    assign cnt_after = cnt + CW'(accept);
    assign out_free  = !bundle_valid || bundle_ready;

    // Same-cycle word is merged so a full or flushed bundle leaves without an extra cycle.
    for (genvar k = 0; k < SLOTS; k++) begin : g_slot
        assign merged[k] = (accept && cnt == CW'(k)) ? word : acc[k];
    end

`ifdef IXU_ENC_TIMEOUT_EN
    localparam int IW = $clog2(TIMEOUT + 1);
    logic [IW-1:0] idle;

    // Fires on the TIMEOUT-th consecutive idle cycle so the close lands on that edge.
    assign timeout_hit = !accept && (cnt != '0) && (idle >= IW'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst || accept || do_close)
            idle <= '0;
        else if (cnt != '0 && idle != IW'(TIMEOUT))
            idle <= idle + 1'b1;
    end
`else
    assign timeout_hit = 1'b0;
`endif

    assign close_req = (cnt_after == CW'(SLOTS)) ||
                       ((flush || flush_pend) && cnt_after != '0) ||
                       timeout_hit;
    assign do_close  = close_req && out_free;

    always_ff @(posedge clk) begin
        if (rst) begin
            acc          <= '0;
            cnt          <= '0;
            flush_pend   <= 1'b0;
            bdata        <= '0;
            bundle_count <= '0;
            bundle_valid <= 1'b0;
            err_illegal  <= 1'b0;
        end else begin
            err_illegal <= accept && illegal && !in_is_nop;
            if (do_close) begin
                bdata        <= merged;
                bundle_count <= cnt_after;
                bundle_valid <= 1'b1;
                acc          <= '0;
                cnt          <= '0;
                flush_pend   <= 1'b0;
            end else begin
                acc <= merged;
                cnt <= cnt_after;
                if ((flush || timeout_hit) && cnt_after != '0)
                    flush_pend <= 1'b1;
                if (bundle_valid && bundle_ready)
                    bundle_valid <= 1'b0;
            end
        end
    end

    assign bundle_data = bdata;
endmodule

// File: tb/tb_ixu_bundle_encoder.sv
// Directed bench for ixu_bundle_encoder (SLOTS=4): encoding, packing, backpressure, errors, reset.
module tb_ixu_bundle_encoder;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [3:0]   in_op = '0;
    logic         in_is_imm = 1'b0;
    logic         in_is_nop = 1'b0;
    logic [4:0]   in_rs1 = '0, in_rs2 = '0, in_rd = '0;
    logic [11:0]  in_imm = '0;
    logic         flush = 1'b0;
    logic         bundle_valid;
    logic         bundle_ready = 1'b0;
    logic [127:0] bundle_data;
    logic [2:0]   bundle_count;
    logic         err_illegal;

    int vectors = 0;
    int miscompares = 0;
    logic [127:0] bun_a, bun_b;

    ixu_bundle_encoder #(.SLOTS(4), .TIMEOUT(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_is_imm(in_is_imm), .in_is_nop(in_is_nop),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_imm(in_imm),
        .flush(flush), .bundle_valid(bundle_valid), .bundle_ready(bundle_ready),
        .bundle_data(bundle_data), .bundle_count(bundle_count), .err_illegal(err_illegal)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_op(input logic [3:0] op, input logic imm_f, input logic nop,
                          input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic [4:0] rd, input logic [11:0] imm);
        in_valid = 1'b1; in_op = op; in_is_imm = imm_f; in_is_nop = nop;
        in_rs1 = rs1; in_rs2 = rs2; in_rd = rd; in_imm = imm;
    endtask

    initial begin
        // reset state
        step(); step();
        chk("rst_valid", 128'(bundle_valid), 128'd0);
        chk("rst_data", bundle_data, 128'd0);
        chk("rst_count", 128'(bundle_count), 128'd0);
        chk("rst_err", 128'(err_illegal), 128'd0);
        rst = 1'b0;
        step();
        chk("rst_ready", 128'(in_ready), 128'd1);

        // ADD x3,x1,x2 then flush
        set_op(4'd0, 1'b0, 1'b0, 5'd1, 5'd2, 5'd3, 12'd0);
        step();
        in_valid = 1'b0; flush = 1'b1;
        step();
        flush = 1'b0;
        chk("add_valid", 128'(bundle_valid), 128'd1);
        chk("add_data", bundle_data, {96'h0, 32'h002081B3});
        chk("add_count", 128'(bundle_count), 128'd1);
        bundle_ready = 1'b1;
        step();
        chk("add_drain", 128'(bundle_valid), 128'd0);

        // four back-to-back ops
        set_op(4'd1, 1'b0, 1'b0, 5'd6, 5'd7, 5'd5, 12'd0);      step();
        set_op(4'd0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd1, 12'hFFF);    step();
        set_op(4'd7, 1'b1, 1'b0, 5'd4, 5'd0, 5'd4, 12'd3);      step();
        chk("b2b_not_yet", 128'(bundle_valid), 128'd0);
        set_op(4'd0, 1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 12'd0);      step();
        in_valid = 1'b0;
        chk("b2b_valid", 128'(bundle_valid), 128'd1);
        chk("b2b_data", bundle_data, {32'h0, 32'h40325213, 32'hFFF00093, 32'h407302B3});
        chk("b2b_count", 128'(bundle_count), 128'd4);
        step();
        chk("b2b_drain", 128'(bundle_valid), 128'd0);

        // backpressure: nine ADDI xk,x0,k with the consumer stalled
        bundle_ready = 1'b0;
        bun_a = '0; bun_b = '0;
        for (int k = 1; k <= 8; k++) begin
            set_op(4'd0, 1'b1, 1'b0, 5'd0, 5'd0, 5'(k), 12'(k));
            if (k <= 4) bun_a[32*(k-1) +: 32] = (32'(k) << 20) | (32'(k) << 7) | 32'h13;
            else        bun_b[32*(k-5) +: 32] = (32'(k) << 20) | (32'(k) << 7) | 32'h13;
            step();
        end
        set_op(4'd0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd9, 12'd9);
        chk("bp_ready_low", 128'(in_ready), 128'd0);
        chk("bp_a_data", bundle_data, bun_a);
        step(); step();
        chk("bp_a_stable", bundle_data, bun_a);
        chk("bp_a_valid", 128'(bundle_valid), 128'd1);
        bundle_ready = 1'b1;
        step();
        chk("bp_b_data", bundle_data, bun_b);
        chk("bp_b_count", 128'(bundle_count), 128'd4);
        chk("bp_ready_back", 128'(in_ready), 128'd1);
        step();
        in_valid = 1'b0;
        chk("bp_b_drain", 128'(bundle_valid), 128'd0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("bp_9_data", bundle_data, {96'h0, 32'h00900493});
        chk("bp_9_count", 128'(bundle_count), 128'd1);

        // illegal ops
        set_op(4'hC, 1'b0, 1'b0, 5'd1, 5'd2, 5'd3, 12'd0);      step();
        chk("ill_err1", 128'(err_illegal), 128'd1);
        set_op(4'd1, 1'b1, 1'b0, 5'd1, 5'd0, 5'd3, 12'd5);      step();
        chk("ill_err2", 128'(err_illegal), 128'd1);
        in_valid = 1'b0; flush = 1'b1;
        step();
        flush = 1'b0;
        chk("ill_err_clr", 128'(err_illegal), 128'd0);
        chk("ill_valid", 128'(bundle_valid), 128'd1);
        chk("ill_data", bundle_data, 128'd0);
        chk("ill_count", 128'(bundle_count), 128'd2);

        // flush coincident with second accept, then flush on empty
        set_op(4'd0, 1'b0, 1'b0, 5'd1, 5'd2, 5'd3, 12'd0);      step();
        flush = 1'b1;
        step();
        in_valid = 1'b0; flush = 1'b0;
        chk("cf_valid", 128'(bundle_valid), 128'd1);
        chk("cf_count", 128'(bundle_count), 128'd2);
        chk("cf_data", bundle_data, {64'h0, 32'h002081B3, 32'h002081B3});
        step();
        chk("cf_drain", 128'(bundle_valid), 128'd0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("empty_flush", 128'(bundle_valid), 128'd0);

        // reset mid-bundle with a pending output
        bundle_ready = 1'b0;
        for (int k = 0; k < 6; k++) begin
            set_op(4'd3, 1'b0, 1'b0, 5'd1, 5'd2, 5'd3, 12'd0);
            step();
        end
        in_valid = 1'b0;
        chk("pre_rst_valid", 128'(bundle_valid), 128'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_rst_valid", 128'(bundle_valid), 128'd0);
        chk("mid_rst_data", bundle_data, 128'd0);
        chk("mid_rst_count", 128'(bundle_count), 128'd0);
        chk("mid_rst_ready", 128'(in_ready), 128'd1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("mid_rst_empty", 128'(bundle_valid), 128'd0);

`ifdef IXU_ENC_TIMEOUT_EN
        set_op(4'd0, 1'b0, 1'b0, 5'd1, 5'd2, 5'd3, 12'd0);
        step();
        in_valid = 1'b0;
        for (int k = 0; k < 7; k++) step();
        chk("to_early", 128'(bundle_valid), 128'd0);
        step();
        chk("to_valid", 128'(bundle_valid), 128'd1);
        chk("to_count", 128'(bundle_count), 128'd1);
        chk("to_data", bundle_data, {96'h0, 32'h002081B3});
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
